dmem_lane: RTL and testbench

- Parametrised successor to the core's flat word RAM (data memory).
- Adds byte/halfword/word access, little-endian byte lanes, and sign/zero-extended loads for LDRB/LDRH/STRB/STRH.
- Adds a valid/ready request interface with programmable read latency and a one-cycle response strobe.
- Detects misaligned and out-of-range accesses and reports them as faults.
- Sits between data_path (addr_data/write_data/we) and the memory array; a thin adapter in data_path drives the handshake.

---
 rtl/dmem_lane.sv | 178 +++++++++++++++++
 tb/tb_dmem_lane.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lane.sv
// Data memory lane: byte/half/word loads and stores over four byte-wide arrays,
// one outstanding request at a time, with programmable response latency.
module dmem_lane #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_fault
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [AW-1:0] DepthA = AW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic [IW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic [1:0]    size_q;
  logic          we_q;
  logic          signed_q;
  logic          fault_q;

  // Lane l holds bits [8l+7:8l] of each word (little-endian).
  logic [7:0] mem [4][DEPTH];

  logic          fault_now;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic          sel_idle;
  logic [IW-1:0] cur_idx;
  logic [1:0]    cur_lane;
  logic [1:0]    cur_size;
  logic          cur_we;
  logic          cur_signed;
  logic          cur_fault;
  logic [31:0]   rd_word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   load_data;
  logic [31:0]   rsp_next;

  // Fault classification of the request presented on the inputs.
  always_comb begin
    fault_now = 1'b0;
    case (req_size)
      2'b00:   fault_now = 1'b0;
      2'b01:   fault_now = req_addr[0];
      2'b10:   fault_now = |req_addr[1:0];
      default: fault_now = 1'b1;
    endcase
    if ({2'b00, req_addr[AW-1:2]} >= DepthA) fault_now = 1'b1;
  end

  // Byte-write enables and lane-replicated store data.
  always_comb begin
    be    = 4'b0000;
    wlane = req_wdata;
    case (req_size)
      2'b00: begin
        be    = 4'b0001 << req_addr[1:0];
        wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Stores commit on the accept edge; faulting stores leave the array untouched.
  always_ff @(posedge clk) begin
    if (!reset && req_ready && req_valid && req_we && !fault_now) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[l][req_addr[IW+1:2]] <= wlane[8*l +: 8];
      end
    end
  end

  // Read source: live request when the response is formed on the accept edge
  // (LATENCY == 1), captured request otherwise.
  always_comb begin
    sel_idle   = (state_q == StIdle);
    cur_idx    = sel_idle ? req_addr[IW+1:2] : idx_q;
    cur_lane   = sel_idle ? req_addr[1:0]    : lane_q;
    cur_size   = sel_idle ? req_size         : size_q;
    cur_we     = sel_idle ? req_we           : we_q;
    cur_signed = sel_idle ? req_signed       : signed_q;
    cur_fault  = sel_idle ? fault_now        : fault_q;
    rd_word    = {mem[3][cur_idx], mem[2][cur_idx], mem[1][cur_idx], mem[0][cur_idx]};
  end

  // Lane extraction and sign/zero extension of the load result.
  always_comb begin
    case (cur_lane)
      2'd0:    byte_v = rd_word[7:0];
      2'd1:    byte_v = rd_word[15:8];
      2'd2:    byte_v = rd_word[23:16];
      default: byte_v = rd_word[31:24];
    endcase
    half_v = cur_lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (cur_size)
      2'b00:   load_data = {{24{cur_signed & byte_v[7]}}, byte_v};
      2'b01:   load_data = {{16{cur_signed & half_v[15]}}, half_v};
      default: load_data = rd_word;
    endcase
    rsp_next = (cur_we || cur_fault) ? 32'd0 : load_data;
  end

  // Request FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_fault <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            idx_q     <= req_addr[IW+1:2];
            lane_q    <= req_addr[1:0];
            size_q    <= req_size;
            we_q      <= req_we;
            signed_q  <= req_signed;
            fault_q   <= fault_now;
            req_ready <= 1'b0;
            if (LATENCY <= 1) begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_rdata <= rsp_next;
              rsp_fault <= cur_fault;
            end else begin
              state_q <= StBusy;
              cnt_q   <= 3'(LATENCY - 1);
            end
          end
        end
        StBusy: begin
          if (cnt_q <= 3'd1) begin
            state_q   <= StResp;
            cnt_q     <= 3'd0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rsp_next;
            rsp_fault <= cur_fault;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'd0;
          rsp_fault <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lane.sv
// Bench for dmem_lane: LATENCY=1 and LATENCY=3 instances driven with the same
// requests, checked against a byte-addressed memory model.
module tb_dmem_lane;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ready1, ready3, valid1, valid3, fault1, fault3;
  logic [31:0] rdata1, rdata3;

  int checks = 0;
  int errors = 0;

  logic [7:0] mm [0:255];

  always #5 clk = ~clk;

  dmem_lane #(.DEPTH(64), .LATENCY(1), .AW(32)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(valid1), .rsp_rdata(rdata1), .rsp_fault(fault1)
  );

  dmem_lane #(.DEPTH(64), .LATENCY(3), .AW(32)) u3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready3),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(valid3), .rsp_rdata(rdata3), .rsp_fault(fault3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-addressed reference: applies stores, returns expected load value and fault.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] d, output logic f);
    int unsigned nb;
    f = (size == 2'b11) || (size == 2'b01 && addr % 2 != 0) ||
        (size == 2'b10 && addr % 4 != 0) || (addr / 4 >= 64);
    d = 32'd0;
    if (!f) begin
      nb = 1 << size;
      if (we) begin
        for (int i = 0; i < nb; i++) mm[addr + i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) d = d | (32'(mm[addr + i]) << (8 * i));
        if (sgn && nb < 4 && d[8*nb-1]) d = d | ~((32'd1 << (8 * nb)) - 32'd1);
      end
    end
  endtask

  // One request to both instances; checks latency, strobe width, ready and data.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got_d, output logic got_f);
    logic [31:0] ed, d1, d3;
    logic        ef, f1, f3;
    int          lat1, lat3, n1, n3;
    model(we, size, sgn, addr, wdata, ed, ef);
    lat1 = 0; lat3 = 0; n1 = 0; n3 = 0;
    d1 = 'x; d3 = 'x; f1 = 'x; f3 = 'x;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    check("ready1_idle", 32'(ready1), 32'd1);
    check("ready3_idle", 32'(ready3), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) check("ready1_resp", 32'(ready1), 32'd0);
      if (k == 2) check("ready1_back", 32'(ready1), 32'd1);
      if (k == 2) check("ready3_busy", 32'(ready3), 32'd0);
      if (k == 4) check("ready3_back", 32'(ready3), 32'd1);
      if (valid1) begin
        n1++;
        if (lat1 == 0) begin lat1 = k; d1 = rdata1; f1 = fault1; end
      end
      if (valid3) begin
        n3++;
        if (lat3 == 0) begin lat3 = k; d3 = rdata3; f3 = fault3; end
      end
    end
    check("lat1", 32'(lat1), 32'd1);
    check("lat3", 32'(lat3), 32'd3);
    check("strobes1", 32'(n1), 32'd1);
    check("strobes3", 32'(n3), 32'd1);
    check("rdata1", d1, ed);
    check("rdata3", d3, ed);
    check("fault1", 32'(f1), 32'(ef));
    check("fault3", 32'(f3), 32'(ef));
    got_d = d1;
    got_f = f1;
  endtask

  // Accept a request, then reset on the following edge.
  task automatic req_reset(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] ed;
    logic        ef;
    int          n3;
    model(we, 2'b10, 1'b0, addr, wdata, ed, ef);
    req_valid = 1'b1; req_we = we; req_size = 2'b10; req_signed = 1'b0;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_busy_valid3", 32'(valid3), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready1", 32'(ready1), 32'd1);
    check("rst_ready3", 32'(ready3), 32'd1);
    check("rst_valid1", 32'(valid1), 32'd0);
    check("rst_valid3", 32'(valid3), 32'd0);
    n3 = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (valid3) n3++;
    end
    check("rst_dropped3", 32'(n3), 32'd0);
  endtask

  initial begin
    logic [31:0] d, a, w;
    logic        f;
    logic [1:0]  sz;
    int          r;
    int          q1[$];
    int          q3[$];

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready1", 32'(ready1), 32'd1);
    check("reset_ready3", 32'(ready3), 32'd1);
    check("reset_valid1", 32'(valid1), 32'd0);
    check("reset_valid3", 32'(valid3), 32'd0);
    check("reset_fault1", 32'(fault1), 32'd0);
    check("reset_rdata1", rdata1, 32'd0);
    check("reset_rdata3", rdata3, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Fill the whole array so every later load has defined contents.
    for (int i = 0; i < 64; i++) do_req(1'b1, 2'b10, 1'b0, 32'(4 * i), $urandom, d, f);

    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, d, f);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, d, f);
    check("word_load", d, 32'hDEADBEEF);
    check("word_fault", 32'(f), 32'd0);

    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, d, f);
    do_req(1'b1, 2'b00, 1'b0, 32'h42, 32'h000000AA, d, f);
    check("bstore_rdata", d, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, d, f);
    check("lane_word", d, 32'h11AA3344);
    do_req(1'b0, 2'b00, 1'b1, 32'h42, 32'h0, d, f);
    check("byte_signed", d, 32'hFFFFFFAA);
    do_req(1'b0, 2'b00, 1'b0, 32'h42, 32'h0, d, f);
    check("byte_unsigned", d, 32'h000000AA);

    do_req(1'b1, 2'b01, 1'b0, 32'h46, 32'h00008001, d, f);
    do_req(1'b0, 2'b01, 1'b1, 32'h46, 32'h0, d, f);
    check("half_signed", d, 32'hFFFF8001);
    do_req(1'b0, 2'b01, 1'b0, 32'h46, 32'h0, d, f);
    check("half_unsigned", d, 32'h00008001);

    do_req(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, d, f);
    check("mis_word_fault", 32'(f), 32'd1);
    check("mis_word_rdata", d, 32'd0);
    do_req(1'b1, 2'b01, 1'b0, 32'h43, 32'h0000FFFF, d, f);
    check("mis_half_fault", 32'(f), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, d, f);
    check("mis_half_nowrite", d, 32'h11AA3344);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, d, f);
    check("oob_fault", 32'(f), 32'd1);
    do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, d, f);
    check("size11_fault", 32'(f), 32'd1);

    // Back-to-back: valid held high, accepts spaced LATENCY+1 apart.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h0;
    for (int c = 0; c < 16; c++) begin
      if (ready1) q1.push_back(c);
      if (ready3) q3.push_back(c);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("stream_accepts1", 32'(q1.size()), 32'd8);
    check("stream_accepts3", 32'(q3.size()), 32'd4);
    for (int i = 1; i < q1.size(); i++) check("stream_gap1", 32'(q1[i] - q1[i-1]), 32'd2);
    for (int i = 1; i < q3.size(); i++) check("stream_gap3", 32'(q3[i] - q3[i-1]), 32'd4);

    // Reset mid-operation: pending load dropped, committed store kept.
    req_reset(1'b0, 32'h20, 32'h0);
    req_reset(1'b1, 32'h30, 32'hCAFEF00D);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, d, f);
    check("store_survives_reset", d, 32'hCAFEF00D);

    // Randomized mix against the model.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom;
      else if (r == 1) a = $urandom_range(256, 1023);
      else a = $urandom_range(0, 255);
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'b11 && $urandom_range(0, 3) != 0) sz = 2'b10;
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      w = $urandom;
      do_req(1'($urandom), sz, 1'($urandom), a, w, d, f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
